// File: rtl/alu_arb_pkg.sv
// Shared types and ALUfn encodings for the ALU arbiter slice.
// ALUfn bit order: {subtract, bool1, bool0, shft, math}.
package alu_arb_pkg;

  localparam int ALUFN_W  = 5;
  localparam int FN_MATH  = 0;
  localparam int FN_SHFT  = 1;
  localparam int FN_BOOL0 = 2;
  localparam int FN_BOOL1 = 3;
  localparam int FN_SUB   = 4;

  localparam logic [ALUFN_W-1:0] ADD = 5'b00001;
  localparam logic [ALUFN_W-1:0] SUB = 5'b10001;
  localparam logic [ALUFN_W-1:0] AND = 5'b00000;
  localparam logic [ALUFN_W-1:0] OR  = 5'b00100;
  localparam logic [ALUFN_W-1:0] XOR = 5'b01000;
  localparam logic [ALUFN_W-1:0] SLL = 5'b00010;
  localparam logic [ALUFN_W-1:0] SRL = 5'b00110;
  localparam logic [ALUFN_W-1:0] SRA = 5'b01110;
  localparam logic [ALUFN_W-1:0] LT  = 5'b10011;
  localparam logic [ALUFN_W-1:0] LTU = 5'b10111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU. math&!shft: add/sub; math&shft: compare (bool0=unsigned);
// !math&shft: shift (bool 01=SRL, 11=SRA, else SLL); else boolean (AND/OR/XOR/NOR).
module alu
  import alu_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]       A,
  input  logic [N-1:0]       B,
  input  logic [ALUFN_W-1:0] ALUfn,
  output logic [N-1:0]       R,
  output logic               FlagZ
);

  localparam int SHW = $clog2(N);

  logic [SHW-1:0] w_shamt;
  logic           w_lt;

  assign w_shamt = B[SHW-1:0];
  assign w_lt    = ALUfn[FN_BOOL0] ? (A < B) : ($signed(A) < $signed(B));

  always_comb begin
    R = '0;
    if (ALUfn[FN_MATH] && !ALUfn[FN_SHFT])
      R = ALUfn[FN_SUB] ? (A - B) : (A + B);
    else if (ALUfn[FN_MATH])
      R = {{(N-1){1'b0}}, w_lt};
    else if (ALUfn[FN_SHFT]) begin
      case ({ALUfn[FN_BOOL1], ALUfn[FN_BOOL0]})
        2'b01:   R = A >> w_shamt;
        2'b11:   R = $signed(A) >>> w_shamt;
        default: R = A << w_shamt;
      endcase
    end else begin
      case ({ALUfn[FN_BOOL1], ALUfn[FN_BOOL0]})
        2'b00:   R = A & B;
        2'b01:   R = A | B;
        2'b10:   R = A ^ B;
        default: R = ~(A | B);
      endcase
    end
  end

  assign FlagZ = (R == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant, searching circularly from last_grant+1.
// With ALU_ARB_LOCK_EN, an active lock restricts the grant to the locked owner.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_last_grant,
`ifdef ALU_ARB_LOCK_EN
  input  logic                    i_lock,
  input  logic [$clog2(NREQ)-1:0] i_owner,
`endif
  output logic [NREQ-1:0]         o_grant
);

  localparam int GW = $clog2(NREQ);

  int   w_idx;
  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = int'(i_last_grant) + i;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && i_req[w_idx[GW-1:0]]) begin
        o_grant[w_idx[GW-1:0]] = 1'b1;
        w_found                = 1'b1;
      end
    end
`ifdef ALU_ARB_LOCK_EN
    // Locked owner gets exclusive access; nobody is granted while it is idle.
    if (i_lock) begin
      o_grant          = '0;
      o_grant[i_owner] = i_req[i_owner];
    end
`endif
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NREQ requesters: IDLE accept, EXEC, RESP.
// Optional ALU_ARB_LOCK_EN adds req_lock to pin the grant to one owner.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ-1:0][N-1:0]          req_a,
  input  logic [NREQ-1:0][N-1:0]          req_b,
  input  logic [NREQ-1:0][ALUFN_W-1:0]    req_fn,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]                 req_lock,
`endif
  output logic [NREQ-1:0]                 rsp_valid,
  input  logic [NREQ-1:0]                 rsp_ready,
  output logic [N-1:0]                    rsp_r,
  output logic                            rsp_z,
  output logic                            busy
);

  localparam int GW = $clog2(NREQ);
  localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);

  state_t              r_state, w_next;
  logic [N-1:0]        r_a, r_b;
  logic [ALUFN_W-1:0]  r_fn;
  logic [GW-1:0]       r_owner, r_last;
  logic [NREQ-1:0]     w_grant;
  logic [GW-1:0]       w_gidx;
  logic                w_accept;
  logic [N-1:0]        w_alu_r;
  logic                w_alu_z;
`ifdef ALU_ARB_LOCK_EN
  logic                r_lock;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req        (req_valid),
    .i_last_grant (r_last),
`ifdef ALU_ARB_LOCK_EN
    .i_lock       (r_lock),
    .i_owner      (r_owner),
`endif
    .o_grant      (w_grant)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_grant[i]) w_gidx = i[GW-1:0];
  end

  assign w_accept = (r_state == IDLE) && (|w_grant);

  // ALU sees only registered operands, so requesters may change inputs after accept.
  alu #(.N(N)) u_alu (
    .A     (r_a),
    .B     (r_b),
    .ALUfn (r_fn),
    .R     (w_alu_r),
    .FlagZ (w_alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready[r_owner]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // req_ready is gated by rst_n so no handshake appears to complete while in reset.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (r_state != IDLE);
    case (r_state)
      IDLE:    if (rst_n) req_ready = w_grant;
      RESP:    rsp_valid[r_owner] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_fn    <= '0;
      r_owner <= '0;
      r_last  <= LAST_RST;
      rsp_r   <= '0;
      rsp_z   <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      r_lock  <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a     <= req_a[w_gidx];
        r_b     <= req_b[w_gidx];
        r_fn    <= req_fn[w_gidx];
        r_owner <= w_gidx;
        r_last  <= w_gidx;
`ifdef ALU_ARB_LOCK_EN
        r_lock  <= req_lock[w_gidx];
`endif
      end
      if (r_state == EXEC) begin
        rsp_r <= w_alu_r;
        rsp_z <= w_alu_z;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a behavioural model.
// Lock scenario is exercised when ALU_ARB_LOCK_EN is defined.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N    = 32;
  localparam int NREQ = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NREQ-1:0]           req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ-1:0][N-1:0]    req_a, req_b;
  logic [NREQ-1:0][4:0]      req_fn;
`ifdef ALU_ARB_LOCK_EN
  logic [NREQ-1:0]           req_lock;
`endif
  logic [N-1:0]              rsp_r;
  logic                      rsp_z, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_fn    (req_fn),
`ifdef ALU_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_r     (rsp_r),
    .rsp_z     (rsp_z),
    .busy      (busy)
  );

  // Reference ALU from the documented field meanings.
  function automatic logic [N-1:0] model_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [4:0] fn);
    int sh;
    sh = int'(b[4:0]);
    if (fn[0] && !fn[1]) return fn[4] ? a - b : a + b;
    if (fn[0]) begin
      if (fn[2]) return {{(N-1){1'b0}}, (a < b)};
      return {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
    end
    if (fn[1]) begin
      case (fn[3:2])
        2'b01:   return a >> sh;
        2'b11:   return $signed(a) >>> sh;
        default: return a << sh;
      endcase
    end
    case (fn[3:2])
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int model_grant(input int last, input logic [NREQ-1:0] v);
    for (int i = 1; i <= NREQ; i++) if (v[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction

  task automatic rand_op(input int i);
    req_a[i]  = $urandom;
    req_b[i]  = ($urandom_range(0, 3) == 0) ? req_a[i] : $urandom;
    req_fn[i] = 5'($urandom_range(0, 31));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
`ifdef ALU_ARB_LOCK_EN
    req_lock = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Waits (bounded) for a req_ready; returns granted index (-1 on timeout) and idle cycles.
  task automatic wait_grant(output int g, output int cyc);
    g = -1; cyc = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready != '0) begin
        g = oh_idx(req_ready);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_rsp(output int o, output int cyc, output logic [N-1:0] r, output logic z);
    o = -1; cyc = 0; r = '0; z = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (rsp_valid != '0) begin
        o = oh_idx(rsp_valid); r = rsp_r; z = rsp_z;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) rand_op(i);
`ifdef ALU_ARB_LOCK_EN
    req_lock = '0;
`endif
    #3;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_r !== '0) begin errors++; $display("FAIL rst_rsp_r: got %h expected 0", rsp_r); end
    checks++; if (rsp_z !== 1'b0) begin errors++; $display("FAIL rst_rsp_z: got %b expected 0", rsp_z); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_add();
    int g, cyc, o; logic [N-1:0] r; logic z;
    req_a[0] = 5; req_b[0] = 7; req_fn[0] = ADD; req_valid = 4'b0001;
    wait_grant(g, cyc);
    req_valid = '0;
    checks++; if (g !== 0) begin errors++; $display("FAIL add_grant: got %0d expected 0", g); end
    checks++; if (cyc !== 0) begin errors++; $display("FAIL add_accept_cycle: got %0d expected 0", cyc); end
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy_exec: got %b expected 1", busy); end
    wait_rsp(o, cyc, r, z);
    checks++; if (o !== 0) begin errors++; $display("FAIL add_owner: got %0d expected 0", o); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL add_latency: got %0d expected 1 cycle after EXEC", cyc); end
    checks++; if (r !== 32'd12) begin errors++; $display("FAIL add_result: got %0d expected 12", r); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL add_z: got %b expected 0", z); end
    rsp_ready = 4'b0001; @(posedge clk); #1 rsp_ready = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_sub();
    int g, cyc, o; logic [N-1:0] r; logic z;
    req_a[1] = 32'h1234; req_b[1] = 32'h1234; req_fn[1] = SUB; req_valid = 4'b0010;
    wait_grant(g, cyc);
    req_valid = '0;
    checks++; if (g !== 1) begin errors++; $display("FAIL sub_grant: got %0d expected 1", g); end
    wait_rsp(o, cyc, r, z);
    checks++; if (o !== 1) begin errors++; $display("FAIL sub_owner: got %0d expected 1", o); end
    checks++; if (r !== '0) begin errors++; $display("FAIL sub_result: got %h expected 0", r); end
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL sub_z: got %b expected 1", z); end
    rsp_ready = 4'b0010; @(posedge clk); #1 rsp_ready = '0;
  endtask

  task automatic test_fairness();
    int g, cyc, o, exp; logic [N-1:0] r, er; logic z;
    do_reset();
    for (int i = 0; i < NREQ; i++) rand_op(i);
    req_valid = '1; rsp_ready = '1; exp = 0;
    for (int k = 0; k < 8; k++) begin
      wait_grant(g, cyc);
      checks++; if (g !== exp) begin errors++; $display("FAIL fair_grant[%0d]: got %0d expected %0d", k, g, exp); end
      if (k > 0) begin
        checks++; if (cyc !== 1) begin errors++; $display("FAIL fair_interval[%0d]: got %0d expected 1", k, cyc); end
      end
      er = (g >= 0) ? model_alu(req_a[g], req_b[g], req_fn[g]) : '0;
      if (g >= 0) rand_op(g);
      wait_rsp(o, cyc, r, z);
      checks++; if (o !== g) begin errors++; $display("FAIL fair_owner[%0d]: got %0d expected %0d", k, o, g); end
      checks++; if (r !== er || z !== (er == '0)) begin errors++; $display("FAIL fair_result[%0d]: got %h/%b expected %h/%b", k, r, z, er, er == '0); end
      exp = (exp + 1) % NREQ;
    end
    req_valid = '0;
    @(posedge clk); #1 rsp_ready = '0;
  endtask

  task automatic test_backpressure();
    int g, cyc, o; logic [N-1:0] r, er; logic z;
    req_a[2] = 32'h0F0F_1234; req_b[2] = 32'h00FF_0001; req_fn[2] = XOR; req_valid = 4'b0100;
    wait_grant(g, cyc);
    checks++; if (g !== 2) begin errors++; $display("FAIL bp_grant: got %0d expected 2", g); end
    er = 32'h0F0F_1234 ^ 32'h00FF_0001;
    req_valid = 4'b0011; rsp_ready = 4'b0001;
    wait_rsp(o, cyc, r, z);
    checks++; if (o !== 2 || r !== er) begin errors++; $display("FAIL bp_rsp: got owner %0d r %h expected owner 2 r %h", o, r, er); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (rsp_r !== er) begin errors++; $display("FAIL bp_stable[%0d]: got %h expected %h", k, rsp_r, er); end
      checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 0100", k, rsp_valid); end
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_no_ready[%0d]: got %b expected 0", k, req_ready); end
    end
    rsp_ready = 4'b0101; @(posedge clk); #1 rsp_ready = '0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant: got %b expected 0001", req_ready); end
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_drop_valid: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int g, cyc, o; logic [N-1:0] r, er; logic z;
    req_a[3] = 32'd100; req_b[3] = 32'd23; req_fn[3] = ADD; req_valid = 4'b1000;
    req_a[0] = 32'hFFFF_FFF0; req_b[0] = 32'd4; req_fn[0] = SRA;
    wait_grant(g, cyc);
    checks++; if (g !== 3) begin errors++; $display("FAIL rm_grant3: got %0d expected 3", g); end
    req_valid = 4'b1001;
    rst_n = 1'b0; #1;
    checks++; if ({req_ready, rsp_valid} !== '0) begin errors++; $display("FAIL rm_handshakes: got ready %b valid %b expected 0", req_ready, rsp_valid); end
    checks++; if (rsp_r !== '0 || rsp_z !== 1'b0) begin errors++; $display("FAIL rm_rsp: got %h/%b expected 0/0", rsp_r, rsp_z); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
    @(posedge clk); #1 rst_n = 1'b1;
    er = model_alu(req_a[0], req_b[0], req_fn[0]);
    wait_grant(g, cyc);
    req_valid = '0;
    checks++; if (g !== 0) begin errors++; $display("FAIL rm_prio0: got %0d expected 0", g); end
    wait_rsp(o, cyc, r, z);
    checks++; if (o !== 0 || r !== er) begin errors++; $display("FAIL rm_rsp_owner: got owner %0d r %h expected owner 0 r %h", o, r, er); end
    rsp_ready = 4'b0001; @(posedge clk); #1 rsp_ready = '0;
  endtask

  task automatic test_random();
    int g, cyc, o, eg, last, d; logic [N-1:0] r, er; logic z;
    do_reset();
    last = NREQ - 1;
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < NREQ; i++) rand_op(i);
      req_valid = 4'($urandom_range(1, 15));
      eg = model_grant(last, req_valid);
      wait_grant(g, cyc);
      checks++; if (g !== eg) begin errors++; $display("FAIL rnd_grant[%0d]: got %0d expected %0d", k, g, eg); end
      er = model_alu(req_a[eg], req_b[eg], req_fn[eg]);
      last = eg;
      req_valid = '0;
      for (int i = 0; i < NREQ; i++) rand_op(i);
      wait_rsp(o, cyc, r, z);
      checks++; if (o !== eg || r !== er || z !== (er == '0)) begin errors++; $display("FAIL rnd_rsp[%0d]: got owner %0d %h/%b expected owner %0d %h/%b", k, o, r, z, eg, er, er == '0); end
      d = $urandom_range(0, 3);
      rsp_ready = 4'($urandom) & ~(4'b0001 << eg);
      repeat (d) begin @(posedge clk); #1; end
      checks++; if (rsp_r !== er) begin errors++; $display("FAIL rnd_hold[%0d]: got %h expected %h", k, rsp_r, er); end
      rsp_ready = 4'b0001 << eg;
      @(posedge clk); #1 rsp_ready = '0;
    end
  endtask

`ifdef ALU_ARB_LOCK_EN
  task automatic test_lock();
    int g, cyc, o; logic [N-1:0] r; logic z;
    do_reset();
    rand_op(1); rand_op(2);
    req_lock = 4'b0010; req_valid = 4'b0110;
    wait_grant(g, cyc);
    checks++; if (g !== 1) begin errors++; $display("FAIL lock_first: got %0d expected 1", g); end
    req_valid = 4'b0100; req_lock = '0;
    wait_rsp(o, cyc, r, z);
    rsp_ready = 4'b0010; @(posedge clk); #1 rsp_ready = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL lock_wait[%0d]: got %b expected 0", k, req_ready); end
      @(posedge clk); #1;
    end
    req_valid = 4'b0110;
    wait_grant(g, cyc);
    checks++; if (g !== 1) begin errors++; $display("FAIL lock_hold: got %0d expected 1", g); end
    req_valid = 4'b0100;
    wait_rsp(o, cyc, r, z);
    rsp_ready = 4'b0010; @(posedge clk); #1 rsp_ready = '0;
    wait_grant(g, cyc);
    req_valid = '0;
    checks++; if (g !== 2) begin errors++; $display("FAIL lock_release: got %0d expected 2", g); end
    wait_rsp(o, cyc, r, z);
    rsp_ready = 4'b0100; @(posedge clk); #1 rsp_ready = '0;
  endtask
`endif

  initial begin
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_fn = '0;
`ifdef ALU_ARB_LOCK_EN
    req_lock = '0;
`endif
    test_reset();
    test_add();
    test_sub();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef ALU_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one `alu` instance (N-bit, 5-bit `ALUfn`, `FlagZ`) among NREQ requesters. It sits between the requesting datapath blocks and the ALU. It accepts one operation at a time through a valid/ready handshake and registers the operands. It drives the ALU for one cycle, then returns the registered result and zero flag to the owning requester through a per-requester response handshake.

## Interface
- `N`, 32: operand/result width, passed to `alu`.
- `NREQ`, 4: number of requesters, ≥2.
- `clk` in 1: the only clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_ready` out NREQ: accept strobe, at most one bit high.
- `req_a` in NREQ×N: operand A per requester.
- `req_b` in NREQ×N: operand B per requester.
- `req_fn` in NREQ×5: ALUfn per requester, {subtract, bool1, bool0, shft, math}.
- `req_lock` in NREQ: present only with `ALU_ARB_LOCK_EN`.
- `rsp_valid` out NREQ: response valid, one-hot or zero.
- `rsp_ready` in NREQ: response consumed.
- `rsp_r` out N: result, shared by all requesters.
- `rsp_z` out 1: FlagZ of the result.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant the first requester with `req_valid` set, searching circularly from `last_grant+1`.
  - `req_ready[g]` is high combinationally in that cycle; the transfer completes on that edge.
  - The edge latches A, B and fn into the operand registers, stores `owner=g`, sets `last_grant=g`, and moves to EXEC.
  - With no valid request, the FSM stays in IDLE and all `req_ready` bits are 0.
- EXEC:
  - The ALU is fed only from the operand registers.
  - `R` and `FlagZ` are latched into `rsp_r` and `rsp_z`.
  - The FSM moves to RESP.
- RESP:
  - `rsp_valid[owner]` is 1.
  - On `rsp_ready[owner]`, the FSM returns to IDLE.
  - `rsp_ready` bits of non-owners are ignored.
  - `rsp_r` and `rsp_z` hold stable until the response handshake completes.
- `req_ready` is 0 in EXEC and RESP.
- All 32 fn codes are legal and passed unmodified. Compare results are zero-extended to N bits, as the ALU produces them.
- Dropping `req_valid` before the grant is allowed; the request is simply not granted.

## Timing
- Reset values:
  - state IDLE
  - `req_ready` 0, `rsp_valid` 0, `rsp_r` 0, `rsp_z` 0, `busy` 0
  - `last_grant` NREQ−1, so requester 0 has first priority
  - lock cleared
- Latency: accept edge at cycle 0; `rsp_valid` rises at cycle 2.
- Minimum issue interval is 3 cycles. With `rsp_ready` tied high, the next accept occurs at cycle 3.
- Reset asserted mid-operation discards the in-flight op. No response is issued and priority returns to requester 0.
- Requests arriving during EXEC or RESP wait; they are not queued internally.
- Fairness: with all requesters continuously valid, grants go 0,1,2,3,0,…

## Configuration
- `ALU_ARB_LOCK_EN` defined:
  - `req_lock` port exists.
  - If the accepted request had `req_lock=1`, the next IDLE grants only that owner, waiting if it is not valid.
  - The lock is released when an accepted op carries `req_lock=0`, or on reset.
  - Use case: multi-word sequences such as add-with-carry chains.
- Undefined: no `req_lock` port; pure round-robin.

## Structure
- Package `alu_arb_pkg` holds:
  - `state_t` enum (IDLE, EXEC, RESP)
  - `ALUFN_W=5`
  - named localparams for the ALUfn bit positions and the common ops: ADD=5'b00001, SUB=5'b10001, AND, OR, XOR, SLL, SRL, SRA, LT, LTU
- Sub-module `rr_arbiter #(NREQ)`:
  - inputs: request vector, `last_grant`, and lock/owner inputs when locking is enabled
  - output: one-hot grant
  - purely combinational
- `alu` is instantiated inside `alu_arbiter`.

## Test plan
- Reset, then req0 with fn=ADD, A=5, B=7 → `req_ready[0]` at cycle 0; `rsp_valid[0]`, `rsp_r`=12, `rsp_z`=0 at cycle 2.
- req1 with fn=SUB, A=B=0x1234 → `rsp_r`=0, `rsp_z`=1.
- All four requesters held valid for 8 ops → grant order 0,1,2,3,0,1,2,3; each response reaches its correct owner.
- Hold `rsp_ready[2]` low for 5 cycles in RESP, while req0 and req1 stay valid → `rsp_r` stays stable, no `req_ready` is asserted, and `rsp_ready[0]` is ignored.
- Assert `rst_n` low during EXEC → all outputs are 0 at once; after release, requests 3 and 0 both valid → 0 is granted.
- With `ALU_ARB_LOCK_EN`: req1 issues with lock=1 while req2 is valid → the next grant is req1; after req1 issues with lock=0, req2 is granted.
